// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and constants for the clock tick scheduler
package clk_sched_pkg;

   // Config handshake sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      APPLY = 2'd2
   } sched_state_e;

   // Divider loaded into every channel at reset (period = DEF_DIV + 1 cycles)
   localparam int DEF_DIV = 1023;

   // Width of a channel index; never narrower than one bit
   function automatic int ch_idx_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_tick_channel.sv
// rtl/clk_tick_channel.sv - one divide-by-(div+1) tick channel with load and restart ports
module clk_tick_channel #(
   parameter int DIV_W   = 10,
   parameter int DEF_DIV = clk_sched_pkg::DEF_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic [DIV_W-1:0] ld_div_i,
   input  logic             ld_en_i,
   input  logic             rst_cnt_i,
   output logic             at_boundary_o,
   output logic             tick_o
);
   import clk_sched_pkg::*;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q, en_d;
   logic             tick_q, tick_d;

   // Count up to div, wrap and strobe; a load or restart zeroes the phase and drops any tick
   always_comb begin
      div_d  = div_q;
      en_d   = en_q;
      cnt_d  = '0;
      tick_d = 1'b0;
      if (en_q) begin
         if (cnt_q == div_q) begin
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (ld_i) begin
         div_d = ld_div_i;
         en_d  = ld_en_i;
      end
      if (ld_i || rst_cnt_i) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         div_q  <= DIV_W'(DEF_DIV);
         en_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         en_q   <= en_d;
         tick_q <= tick_d;
      end
   end

   // Safe to reconfigure: channel idle, or it is on the last cycle of its period
   assign at_boundary_o = !en_q || (cnt_q == div_q);
   assign tick_o        = tick_q;

endmodule

// File: rtl/clk_tick_scheduler.sv
// rtl/clk_tick_scheduler.sv - per-channel clock-enable tick generator with glitch-free reconfiguration
module clk_tick_scheduler #(
   parameter  int N_CH    = 4,
   parameter  int DIV_W   = 10,
   parameter  int DEF_DIV = clk_sched_pkg::DEF_DIV,
   localparam int CH_W    = clk_sched_pkg::ch_idx_w(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_en,
   input  logic             cfg_resync,
   output logic [N_CH-1:0]  tick_o,
   output logic             busy
);
   import clk_sched_pkg::*;

   sched_state_e     state_q, state_d;
   logic             init_q;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q, en_d;
   logic             resync_q, resync_d;
   logic [N_CH-1:0]  at_bnd;
   logic [N_CH-1:0]  ld_vec;
   logic [N_CH-1:0]  rst_cnt_vec;

   // Ready only once the first edge after reset has been seen
   assign cfg_ready = init_q && (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   // Accept a request, wait for the target's period boundary, then apply in one cycle
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      div_d       = div_q;
      en_d        = en_q;
      resync_d    = resync_q;
      ld_vec      = '0;
      rst_cnt_vec = '0;
      case (state_q)
         IDLE: begin
            if (cfg_valid && cfg_ready) begin
               ch_d     = cfg_ch;
               div_d    = cfg_div;
               en_d     = cfg_en;
               resync_d = cfg_resync;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (at_bnd[ch_q]) begin
               state_d = APPLY;
            end
         end
         APPLY: begin
            ld_vec[ch_q] = 1'b1;
            if (resync_q) begin
               rst_cnt_vec = {N_CH{1'b1}};
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state and latched request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         init_q   <= 1'b0;
         ch_q     <= '0;
         div_q    <= '0;
         en_q     <= 1'b0;
         resync_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         init_q   <= 1'b1;
         ch_q     <= ch_d;
         div_q    <= div_d;
         en_q     <= en_d;
         resync_q <= resync_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      clk_tick_channel #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .ld_i          (ld_vec[i]),
         .ld_div_i      (div_q),
         .ld_en_i       (en_q),
         .rst_cnt_i     (rst_cnt_vec[i]),
         .at_boundary_o (at_bnd[i]),
         .tick_o        (tick_o[i])
      );
   end

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// tb/tb_clk_tick_scheduler.sv - self-checking bench for clk_tick_scheduler
module tb_clk_tick_scheduler;
   localparam int N_CH    = 4;
   localparam int DIV_W   = 10;
   localparam int DEF_DIV = 1023;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_ch = '0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic             cfg_en = 1'b0;
   logic             cfg_resync = 1'b0;
   logic [N_CH-1:0]  tick_o;
   logic             busy;

   always #5 clk = ~clk;

   clk_tick_scheduler #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_en     (cfg_en),
      .cfg_resync (cfg_resync),
      .tick_o     (tick_o),
      .busy       (busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference: each channel ticks on edges R + k*(div+1), k>=1, where R is its last restart edge
   int m_r   [N_CH];
   int m_div [N_CH];
   bit m_en  [N_CH];
   bit m_init, m_pend, m_nen, m_nres;
   int m_p, m_ch, m_ndiv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [N_CH-1:0] m_ticks();
      logic [N_CH-1:0] t;
      for (int i = 0; i < N_CH; i++)
         t[i] = m_en[i] && (cyc > m_r[i]) && (((cyc - m_r[i]) % (m_div[i] + 1)) == 0);
      return t;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_r[i] = 0; m_div[i] = DEF_DIV; m_en[i] = 1'b0;
      end
      m_init = 1'b0;
      m_pend = 1'b0;
   endtask

   // Apply the specification's rules for the clock edge numbered cyc
   task automatic model_edge();
      int e;
      if (!rst_n) begin
         model_reset();
      end else if (!m_init) begin
         m_init = 1'b1;
      end else if (m_pend) begin
         if (cyc == m_p) begin
            m_en[m_ch]  = m_nen;
            m_div[m_ch] = m_ndiv;
            m_r[m_ch]   = cyc;
            if (m_nres) for (int i = 0; i < N_CH; i++) m_r[i] = cyc;
            m_pend = 1'b0;
         end
      end else if (cfg_valid) begin
         m_ch = int'(cfg_ch); m_ndiv = int'(cfg_div); m_nen = cfg_en; m_nres = cfg_resync;
         e = cyc + 1;
         while (m_en[m_ch] && (((e - m_r[m_ch]) % (m_div[m_ch] + 1)) != 0)) e++;
         m_p    = e + 1;
         m_pend = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      chk("tick_o", tick_o, m_ticks());
      chk("cfg_ready", cfg_ready, m_init && !m_pend);
      chk("busy", busy, m_pend);
   endtask

   task automatic send(input int ch, input int dv, input bit en, input bit res, output int bcyc);
      int guard = 0;
      cfg_ch = 2'(ch); cfg_div = DIV_W'(dv); cfg_en = en; cfg_resync = res; cfg_valid = 1'b1;
      while (!cfg_ready && guard < 2000) begin step(); guard++; end
      step();
      cfg_valid = 1'b0;
      cfg_ch = 2'($urandom); cfg_div = DIV_W'($urandom); cfg_en = 1'($urandom); cfg_resync = 1'($urandom);
      bcyc = 0;
      while (busy && guard < 4000) begin bcyc++; step(); guard++; end
      if (guard >= 4000) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout cyc=%0d got busy=%0b expected busy=0", cyc, busy);
      end
   endtask

   task automatic wait_tick(input int ch, input int maxc, output int k);
      k = 0;
      do begin step(); k++; end while (!tick_o[ch] && k < maxc);
      if (!tick_o[ch]) k = -1;
   endtask

   typedef struct {
      int ch;
      int dv;
      bit en;
      bit res;
      int exp_busy;
      int exp_first;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int b, k, k0, k1;
      tbl[0] = '{ch: 0, dv: 3, en: 1'b1, res: 1'b0, exp_busy: 2, exp_first: 4};
      tbl[1] = '{ch: 2, dv: 0, en: 1'b1, res: 1'b0, exp_busy: 2, exp_first: 1};
      tbl[2] = '{ch: 1, dv: 9, en: 1'b1, res: 1'b0, exp_busy: 2, exp_first: 10};
      tbl[3] = '{ch: 3, dv: 5, en: 1'b0, res: 1'b0, exp_busy: 2, exp_first: -1};
      model_reset();

      // T1: reset with random config activity
      #1 rst_n = 1'b0;
      #1;
      chk("t1_async_tick", tick_o, '0);
      chk("t1_async_ready", cfg_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'($urandom); cfg_ch = 2'($urandom); cfg_div = DIV_W'($urandom);
         cfg_en = 1'($urandom); cfg_resync = 1'($urandom);
         step();
      end
      cfg_valid = 1'b0;
      rst_n = 1'b1;
      step();
      chk("t1_ready_rise", cfg_ready, 1'b1);
      for (int i = 0; i < 5; i++) step();

      // T2/T4: table of transactions on fresh channels
      foreach (tbl[j]) begin
         send(tbl[j].ch, tbl[j].dv, tbl[j].en, tbl[j].res, b);
         chk("tbl_busy", b, tbl[j].exp_busy);
         if (tbl[j].exp_first > 0) begin
            wait_tick(tbl[j].ch, 40, k);
            chk("tbl_first_tick", k, tbl[j].exp_first);
            wait_tick(tbl[j].ch, 40, k);
            chk("tbl_period", k, tbl[j].dv + 1);
         end else begin
            for (int i = 0; i < 12; i++) step();
         end
      end

      // T3: ch1 running div=9, rewrite to div=2 while its count is 3
      while (((cyc - m_r[1]) % 10) != 3) step();
      send(1, 2, 1'b1, 1'b0, b);
      chk("t3_busy", b, 7);
      wait_tick(1, 20, k);
      chk("t3_first", k, 3);
      wait_tick(1, 20, k);
      chk("t3_period", k, 3);

      // T4: disable ch2 running div=0
      send(2, 0, 1'b0, 1'b0, b);
      chk("t4_busy", b, 2);
      chk("t4_no_tick", tick_o[2], 1'b0);
      for (int i = 0; i < 8; i++) step();

      // T5: misaligned channels then resync via a write to a disabled channel
      send(0, 4, 1'b1, 1'b0, b);
      send(1, 6, 1'b1, 1'b0, b);
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
      send(3, 0, 1'b0, 1'b1, b);
      chk("t5_busy", b, 2);
      k0 = -1; k1 = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (tick_o[0] && k0 < 0) k0 = i;
         if (tick_o[1] && k1 < 0) k1 = i;
      end
      chk("t5_ch0_first", k0, 5);
      chk("t5_ch1_first", k1, 7);

      // Randomized traffic, including requests while busy
      for (int i = 0; i < 3000; i++) begin
         cfg_valid  = ($urandom % 4) == 0;
         cfg_ch     = 2'($urandom);
         cfg_div    = DIV_W'($urandom % 12);
         cfg_en     = ($urandom % 4) != 0;
         cfg_resync = ($urandom % 5) == 0;
         step();
      end
      cfg_valid = 1'b0;
      while (busy) step();

      // T6: reset pulse while a transaction sits in WAIT
      send(1, 15, 1'b1, 1'b0, b);
      while (((cyc - m_r[1]) % 16) != 2) step();
      cfg_ch = 2'd1; cfg_div = DIV_W'(5); cfg_en = 1'b1; cfg_resync = 1'b0; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("t6_in_wait", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_tick", tick_o, '0);
      chk("t6_async_busy", busy, 1'b0);
      chk("t6_async_ready", cfg_ready, 1'b0);
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      step();
      chk("t6_ready", cfg_ready, 1'b1);
      for (int i = 0; i < 20; i++) step();
      send(3, DEF_DIV, 1'b1, 1'b0, b);
      chk("t6_busy", b, 2);
      wait_tick(3, 1100, k);
      chk("t6_def_first", k, DEF_DIV + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
